// File: rtl/qsm_pkg.sv
// Shared widths, types and FSM encoding for the QSM maximum-likelihood selector.
package qsm_pkg;
  localparam int unsigned N     = 16;
  localparam int unsigned Q     = 8;
  localparam int unsigned LEVEL = 256;
  localparam int unsigned MET_W = 2*N + 2;

  typedef logic signed [N-1:0] data_t;
  typedef logic signed [N:0]   err_t;
  typedef logic [MET_W-1:0]    met_t;

  // x[0..3] = I1, Q1, I2, Q2
  typedef struct packed {
    logic [3:0]      q;
    logic [3:0][N-1:0] x;
  } cand_t;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;
endpackage

// File: rtl/qsm_slicer.sv
// Combinational nearest-PAM-level slicer for one value; returns the level and x - level.
module qsm_slicer
  import qsm_pkg::*;
#(
  parameter int unsigned M_QAM = 4
) (
  input  logic signed [N-1:0] x_i,
  output logic signed [N-1:0] s_o,
  output logic signed [N:0]   e_o
);
  localparam data_t L1 = data_t'(LEVEL);
  localparam data_t L3 = data_t'(3*LEVEL);
  localparam data_t TH = data_t'(2*LEVEL);

  always_comb begin
    s_o = L1;
    if (M_QAM == 16) begin
      // thresholds resolve upward: 2*LEVEL -> 3*LEVEL, 0 -> +LEVEL
      if (x_i >= TH)       s_o = L3;
      else if (!x_i[N-1])  s_o = L1;
      else if (x_i >= -TH) s_o = -L1;
      else                 s_o = -L3;
    end else begin
      s_o = x_i[N-1] ? -L1 : L1;
    end
    e_o = err_t'(x_i) - err_t'(s_o);
  end
endmodule

// File: rtl/qsm_ml_select.sv
// Per-frame minimum squared-error selection over NUM_Q candidate estimates (slice, square-sum, compare).
module qsm_ml_select
  import qsm_pkg::*;
#(
  parameter int unsigned NUM_Q = 16,
  parameter int unsigned M_QAM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_frame,
  input  logic                 cand_valid,
  input  logic [3:0]           cand_q,
  input  logic signed [N-1:0]  xI1_in,
  input  logic signed [N-1:0]  xQ1_in,
  input  logic signed [N-1:0]  xI2_in,
  input  logic signed [N-1:0]  xQ2_in,
  output logic                 busy,
  output logic                 det_valid,
  output logic [3:0]           det_q,
  output logic signed [N-1:0]  det_sI1,
  output logic signed [N-1:0]  det_sQ1,
  output logic signed [N-1:0]  det_sI2,
  output logic signed [N-1:0]  det_sQ2,
  output logic [MET_W-1:0]     det_metric,
  output logic                 err_extra
);
  localparam int unsigned CW = $clog2(NUM_Q + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  logic          err_q, err_d;
  logic          accept, acc_last, fire, better;

  data_t xin [4];
  data_t xs  [4];
  err_t  xe  [4];

  logic  v1_q, v1_d, last1_q, last1_d, first1_q, first1_d;
  cand_t c1_q, c1_d;
  err_t  e1_q [4];
  err_t  e1_d [4];

  logic  v2_q, v2_d, last2_q, last2_d, first2_q, first2_d;
  cand_t c2_q, c2_d;
  met_t  m2_q, m2_d;

  cand_t best_q, best_d, detc_q, detc_d;
  met_t  bmet_q, bmet_d, detm_q, detm_d;
  logic  detv_q, detv_d;

  logic signed [MET_W-1:0] ext;
  met_t                    sum;

  assign xin = '{xI1_in, xQ1_in, xI2_in, xQ2_in};

  for (genvar g = 0; g < 4; g++) begin : g_slice
    qsm_slicer #(.M_QAM(M_QAM)) u_slicer (
      .x_i (xin[g]),
      .s_o (xs[g]),
      .e_o (xe[g])
    );
  end

  always_comb begin
    // start_frame clears the count before the same-cycle candidate is counted
    cnt_base = start_frame ? '0 : cnt_q;
    accept   = cand_valid && (start_frame || (state_q != FLUSH && cnt_q < CW'(NUM_Q)));
    acc_last = (cnt_base == CW'(NUM_Q - 1));
    fire     = v2_q && last2_q && !start_frame;
    cnt_d    = accept ? cnt_base + CW'(1) : cnt_base;
    err_d    = start_frame ? 1'b0 : (err_q | (cand_valid && !accept));

    state_d = state_q;
    if (start_frame) begin
      state_d = !accept ? IDLE : (acc_last ? FLUSH : COLLECT);
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = acc_last ? FLUSH : COLLECT;
        COLLECT: if (accept && acc_last) state_d = FLUSH;
        FLUSH:   if (fire) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    v1_d     = accept;
    last1_d  = acc_last;
    first1_d = (cnt_base == '0);
    c1_d.q   = cand_q;
    for (int unsigned i = 0; i < 4; i++) begin
      c1_d.x[i] = xs[i];
      e1_d[i]   = xe[i];
    end

    sum = '0;
    ext = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ext = {{(MET_W-N-1){e1_q[i][N]}}, e1_q[i]};
      sum = sum + met_t'(ext * ext);
    end
    v2_d     = v1_q && !start_frame;
    last2_d  = last1_q;
    first2_d = first1_q;
    c2_d     = c1_q;
    m2_d     = sum;

    better = v2_q && !start_frame && (first2_q || m2_q < bmet_q);
    best_d = best_q;
    bmet_d = bmet_q;
    if (better) begin
      best_d = c2_q;
      bmet_d = m2_q;
    end
    detv_d = fire;
    detc_d = detc_q;
    detm_d = detm_q;
    if (fire) begin
      detc_d = best_d;
      detm_d = bmet_d;
      bmet_d = '1;
    end
    if (start_frame) bmet_d = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      first1_q <= 1'b0;
      c1_q     <= '0;
      e1_q     <= '{default: '0};
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      first2_q <= 1'b0;
      c2_q     <= '0;
      m2_q     <= '0;
      best_q   <= '0;
      bmet_q   <= '1;
      detv_q   <= 1'b0;
      detc_q   <= '0;
      detm_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      first1_q <= first1_d;
      c1_q     <= c1_d;
      e1_q     <= e1_d;
      v2_q     <= v2_d;
      last2_q  <= last2_d;
      first2_q <= first2_d;
      c2_q     <= c2_d;
      m2_q     <= m2_d;
      best_q   <= best_d;
      bmet_q   <= bmet_d;
      detv_q   <= detv_d;
      detc_q   <= detc_d;
      detm_q   <= detm_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign det_valid  = detv_q;
  assign det_q      = detc_q.q;
  assign det_sI1    = detc_q.x[0];
  assign det_sQ1    = detc_q.x[1];
  assign det_sI2    = detc_q.x[2];
  assign det_sQ2    = detc_q.x[3];
  assign det_metric = detm_q;
  assign err_extra  = err_q;
endmodule

// File: doc/qsm_ml_select.md
Name: qsm_ml_select

Overview:
- Downstream of x_calculate in the QSM MIMO detector. Receives one candidate estimate per antenna-combination index q: four Q(N-Q) fixed-point values (xI1, xQ1, xI2, xQ2).
- Slices each value to the nearest PAM level and computes a squared-error metric per candidate.
- Tracks the minimum-metric q across NUM_Q candidates, then emits one detection result per frame: best q, its sliced symbols and its metric.

Parameters:
- Q, 8, fractional bits of all data inputs and outputs.
- N, 16, data word width, two's complement.
- NUM_Q, 16, candidates per frame.
- M_QAM, 4, constellation per I/Q pair: 4 (levels ±1) or 16 (levels ±1, ±3).
- LEVEL, 256, the value 1.0 in Q8.8. Constellation unit amplitude.
- MET_W, 2*N+2, metric width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_frame  in  1  one-cycle pulse; clears the accumulated state for a new frame.
- cand_valid  in  1  candidate present this cycle. Wire this from x_calculate q_done.
- cand_q  in  4  q index of the candidate.
- xI1_in, xQ1_in, xI2_in, xQ2_in  in  N each  signed candidate estimates.
- busy  out  1  high from the first accepted candidate until det_valid.
- det_valid  out  1  one-cycle result pulse.
- det_q  out  4  q with the minimum metric.
- det_sI1, det_sQ1, det_sI2, det_sQ2  out  N each  sliced symbols of det_q.
- det_metric  out  MET_W  minimum metric, unsigned.
- err_extra  out  1  sticky; set when a candidate arrives after NUM_Q candidates and before the next start_frame.

Behaviour:
- Reset: every output is 0, the counter is 0, the best metric is all-ones, and the pipeline valid bits are 0.
- rst has priority over everything. A rst mid-frame discards all partial state and produces no det_valid.

Slicer, per value, with x >= 0 mapping to the positive side:
- M_QAM=4: s = +LEVEL if x >= 0, otherwise -LEVEL.
- M_QAM=16: thresholds at 0 and ±2*LEVEL; s is one of ±LEVEL, ±3*LEVEL. A value exactly on a threshold maps to the larger-magnitude level on the positive side; x = 2*LEVEL gives 3*LEVEL.
- The error is e = x - s, computed at N+1 bits so it cannot overflow.

Metric:
- sum of the four e², computed in full precision at MET_W bits, with no truncation or saturation.

Pipeline (q tag and symbols travel with the data):
- S1 (registered): slice and compute errors.
- S2 (registered): square and sum.
- S3: compare against the running minimum and update it.

Minimum update rule:
- Update when metric < best_metric (strict), so a tie keeps the earlier-arriving candidate.
- The first candidate of a frame always loads the minimum.

Counting and result:
- The counter increments on every accepted cand_valid.
- When the NUM_Q-th candidate leaves S3, det_valid pulses. This is 3 cycles after the cycle that candidate was accepted.
- In the same cycle as det_valid, busy falls and the minimum resets.

States:
- IDLE: go to COLLECT on cand_valid.
- COLLECT: go to FLUSH after NUM_Q candidates are accepted.
- FLUSH: wait for the pipeline to drain, pulse det_valid, return to IDLE.

Simultaneous and boundary events:
- start_frame together with cand_valid: the state is cleared and the candidate is accepted as the first of the new frame.
- start_frame while in COLLECT or FLUSH: the frame is abandoned, no det_valid is produced, candidates still in flight are flushed, and err_extra is cleared.
- cand_valid while in FLUSH, or after the count reaches NUM_Q: the candidate is ignored and err_extra is set.
- cand_q is carried only as the result tag. Its order is not checked.
- Back-to-back cand_valid on every cycle is supported with no stalls.

Decomposition:
- Package qsm_pkg: N, Q, LEVEL, MET_W, typedef data_t (signed N), typedef met_t (MET_W), typedef cand_t (q plus four data_t), and state enum {IDLE, COLLECT, FLUSH}.
- Sub-module qsm_slicer: a combinational single-value slicer returning s and e. It is instantiated four times in S1.

Test Plan:
- 4-QAM, q≠5 candidates (0x0180 ×4), q=5 candidate (0x0100, 0xFF00, 0x0100, 0x0100) -> det_q=5, det_metric=0, symbols 0x0100, 0xFF00, 0x0100, 0x0100; det_valid 3 cycles after the 16th candidate.
- 4-QAM, all 16 candidates (0x0180 ×4), back-to-back -> det_q=0 (tie keeps earliest), det_metric=65536, symbols all 0x0100.
- 16-QAM slicing, single-candidate frame (NUM_Q=1):
  - 0x0250 -> s=0x0300, e²=30976.
  - 0x0000 -> s=0x0100.
  - 0x0200 -> s=0x0300.
  - 0xFD80 -> s=0xFD00, e²=16384.
  - Check the summed metric exactly.
- Extreme input, 16-QAM, all four values 0x7FFF -> s=0x0300 each, det_metric=4095744004, with no wrap.
- rst asserted after 7 candidates -> no det_valid and busy=0. A following full frame then gives the correct result.
- start_frame after 9 candidates, followed by a full frame with best q=12 -> exactly one det_valid with det_q=12. A 17th candidate sets err_extra, and the next start_frame clears it.
